// File: rtl/maxpool_pkg.sv
// Shared types and sizing helpers for the 2x2 stride-2 max-pool sequencer.
package maxpool_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_IMG_W      = 416;
  localparam int DEFAULT_IMG_H      = 416;
  localparam int HALF_W             = DEFAULT_IMG_W / 2;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] pixel_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int COL_W = cnt_width(DEFAULT_IMG_W);
  localparam int ROW_W = cnt_width(DEFAULT_IMG_H);

endpackage

// File: rtl/maxpool_ctrl_if.sv
// Pixel-in / pooled-pixel-out valid/ready streams plus the frame-done pulse.
interface maxpool_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         frame_done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, frame_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, frame_done
  );
endinterface

// File: rtl/pool_line_buf.sv
// Half-row store of horizontal partial maxima: synchronous write, combinational read.
module pool_line_buf #(
  parameter int DEPTH = 208,
  parameter int W     = 16,
  parameter int AW    = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic signed [W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic signed [W-1:0] rdata
);
  logic signed [W-1:0] mem [DEPTH];

  // Contents need no reset: every entry is written on an even row before use.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/signed_max.sv
// Pairwise two's-complement maximum; on a tie the second operand is returned.
module signed_max #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  assign y = (a > b) ? a : b;
endmodule

// File: rtl/maxpool_ctrl.sv
// Streaming 2x2 stride-2 max-pool: raster pixels in, one pooled pixel per window out.
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IMG_W      = DEFAULT_IMG_W,
  parameter int IMG_H      = DEFAULT_IMG_H
) (
  input logic           clk,
  input logic           rst,
  maxpool_ctrl_if.slave bus
);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int CW       = cnt_width(IMG_W);
  localparam int RW       = cnt_width(IMG_H);
  localparam int AW       = cnt_width(LB_DEPTH);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_geometry
    $fatal(1, "maxpool_ctrl: IMG_W and IMG_H must be even and >= 2");
  end

  logic [CW-1:0]               col_r;
  logic [RW-1:0]               row_r;
  logic signed [DATA_WIDTH-1:0] hold_r;
  logic signed [DATA_WIDTH-1:0] out_data_r;
  logic                        out_valid_r;
  logic                        last_flag_r;

  logic                        in_ready_s;
  logic                        accept_s;
  logic                        col_last_s;
  logic                        row_last_s;
  logic                        lb_we_s;
  logic                        load_s;
  logic [AW-1:0]               lb_idx_s;
  logic signed [DATA_WIDTH-1:0] lb_rdata_s;
  logic signed [DATA_WIDTH-1:0] h_max_s;
  logic signed [DATA_WIDTH-1:0] v_max_s;

  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign col_last_s = (col_r == CW'(IMG_W - 1));
  assign row_last_s = (row_r == RW'(IMG_H - 1));
  assign lb_idx_s   = AW'(col_r >> 1);
  assign lb_we_s    = accept_s && col_r[0] && !row_r[0];
  assign load_s     = accept_s && col_r[0] && row_r[0];

  signed_max #(.W(DATA_WIDTH)) u_hmax (
    .a (hold_r),
    .b (bus.in_data),
    .y (h_max_s)
  );

  signed_max #(.W(DATA_WIDTH)) u_vmax (
    .a (lb_rdata_s),
    .b (h_max_s),
    .y (v_max_s)
  );

  pool_line_buf #(.DEPTH(LB_DEPTH), .W(DATA_WIDTH), .AW(AW)) u_line_buf (
    .clk   (clk),
    .we    (lb_we_s),
    .waddr (lb_idx_s),
    .wdata (h_max_s),
    .raddr (lb_idx_s),
    .rdata (lb_rdata_s)
  );

  // Raster position counters and the even-column hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r  <= '0;
      row_r  <= '0;
      hold_r <= '0;
    end else if (accept_s) begin
      if (col_last_s) begin
        col_r <= '0;
        row_r <= row_last_s ? '0 : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
      if (!col_r[0]) begin
        hold_r <= bus.in_data;
      end
    end
  end

  // Single-entry output register; a new load wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      last_flag_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= v_max_s;
      last_flag_r <= col_last_s && row_last_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
      last_flag_r <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.frame_done = out_valid_r && bus.out_ready && last_flag_r;
endmodule

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench for maxpool_ctrl on a 4x4 image: vector table, scoreboard, corner sequences.
module tb_maxpool_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxpool_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  maxpool_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic signed [DW-1:0] d;
    logic                 last;
  } exp_t;

  typedef struct {
    logic signed [DW-1:0] p [4];
    logic signed [DW-1:0] exp;
  } vec_t;

  exp_t                 sb_q [$];
  logic signed [DW-1:0] got [$];
  logic signed [DW-1:0] ref_got [$];
  vec_t                 tbl [8];
  logic signed [DW-1:0] rnd_pix [48];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int frames_seen = 0;
  int cyc = 0;
  int stall_left = 0;

  int                   m_col = 0;
  int                   m_row = 0;
  logic signed [DW-1:0] m_hold = '0;
  logic signed [DW-1:0] m_lb [W/2];
  logic                 exp_pend = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_col = 0;
    m_row = 0;
    m_hold = '0;
    exp_pend = 1'b0;
  endtask

  task automatic model_push(input logic signed [DW-1:0] d, output logic new_out);
    logic signed [DW-1:0] hm;
    exp_t e;
    new_out = 1'b0;
    if (m_col % 2 == 0) begin
      m_hold = d;
    end else begin
      hm = smax(m_hold, d);
      if (m_row % 2 == 0) begin
        m_lb[m_col/2] = hm;
      end else begin
        e.d = smax(m_lb[m_col/2], hm);
        e.last = (m_col == W-1) && (m_row == H-1);
        sb_q.push_back(e);
        new_out = 1'b1;
      end
    end
    if (m_col == W-1) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic step(input logic v, input logic signed [DW-1:0] d, input logic ordy_in, output logic acc);
    logic ordy;
    logic new_out;
    exp_t e;
    ordy = ordy_in;
    if (exp_pend && stall_left > 0) begin
      ordy = 1'b0;
      stall_left--;
    end
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = ordy;
    #1;
    cyc++;
    check("out_valid", bus.out_valid, exp_pend);
    check("in_ready", bus.in_ready, !exp_pend || ordy);
    if (bus.frame_done === 1'b1) frames_seen++;
    if (bus.out_valid === 1'b1 && sb_q.size() == 0) begin
      check("unexpected_output", 1, 0);
    end else if (bus.out_valid === 1'b1 && ordy) begin
      e = sb_q.pop_front();
      check("out_data", bus.out_data, e.d);
      check("frame_done", bus.frame_done, e.last);
      got.push_back(bus.out_data);
    end else begin
      if (bus.out_valid === 1'b1) check("held_out_data", bus.out_data, sb_q[0].d);
      check("frame_done_idle", bus.frame_done, 0);
    end
    acc = v && (bus.in_ready === 1'b1);
    new_out = 1'b0;
    if (acc) model_push(d, new_out);
    if (new_out) exp_pend = 1'b1;
    else if (exp_pend && ordy) exp_pend = 1'b0;
  endtask

  task automatic feed_pixel(input logic signed [DW-1:0] d, input logic rnd);
    logic acc;
    for (int k = 0; k < 200; k++) begin
      step(rnd ? 1'($urandom % 2) : 1'b1, d, rnd ? 1'($urandom % 2) : 1'b1, acc);
      if (acc) return;
    end
    check("feed_timeout", 0, 1);
  endtask

  task automatic drain(input logic rnd);
    logic acc;
    for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0 && !exp_pend) return;
      step(1'b0, '0, rnd ? 1'($urandom % 2) : 1'b1, acc);
    end
    check("drain_timeout", 0, 1);
  endtask

  task automatic set_vec(input int i, input int a, input int b, input int c, input int d, input int e);
    tbl[i].p[0] = DW'(a);
    tbl[i].p[1] = DW'(b);
    tbl[i].p[2] = DW'(c);
    tbl[i].p[3] = DW'(d);
    tbl[i].exp  = DW'(e);
  endtask

  task automatic feed_table_frame(input int f);
    int wi;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        wi = f*4 + (r/2)*2 + c/2;
        feed_pixel(tbl[wi].p[(r%2)*2 + c%2], 1'b0);
      end
    end
  endtask

  initial begin
    logic acc;
    int fs0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_frame_done", bus.frame_done, 0);
    check("reset_in_ready", bus.in_ready, 1);
    rst = 1'b0;

    set_vec(0, 1, 5, 4, 0, 5);
    set_vec(1, -3, 2, 7, -8, 7);
    set_vec(2, -9, -2, -7, -16, -2);
    set_vec(3, -32768, 32767, -1, -32768, 32767);
    set_vec(4, 3, 3, 3, 3, 3);
    set_vec(5, -1, -5, -4, 10, 10);
    set_vec(6, 100, -100, 200, -200, 200);
    set_vec(7, -32768, -32768, -32768, -32768, -32768);

    // Two table frames; the first pending output is held back 5 cycles.
    got.delete();
    stall_left = 5;
    fs0 = frames_seen;
    feed_table_frame(0);
    feed_table_frame(1);
    drain(1'b0);
    check("table_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) check($sformatf("table_vec%0d", i), got[i], tbl[i].exp);
    end
    check("table_frames", frames_seen - fs0, 2);

    // Reset mid-frame with an output pending, then a clean frame from (0,0).
    for (int i = 0; i < 6; i++) feed_pixel(DW'(i * 3 - 7), 1'b0);
    step(1'b1, DW'(99), 1'b0, acc);
    check("pending_before_rst", bus.out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    model_reset();
    got.delete();
    feed_table_frame(0);
    drain(1'b0);
    check("post_rst_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check($sformatf("post_rst_vec%0d", i), got[i], tbl[i].exp);
    end

    // Back-to-back random frames at full rate, then with random valid/ready.
    for (int i = 0; i < 48; i++) rnd_pix[i] = DW'($urandom);
    got.delete();
    fs0 = frames_seen;
    cyc = 0;
    for (int i = 0; i < 48; i++) feed_pixel(rnd_pix[i], 1'b0);
    check("full_rate_cycles", cyc, 48);
    drain(1'b0);
    check("full_rate_frames", frames_seen - fs0, 3);
    ref_got = got;
    check("full_rate_count", ref_got.size(), 12);

    got.delete();
    fs0 = frames_seen;
    for (int i = 0; i < 48; i++) feed_pixel(rnd_pix[i], 1'b1);
    drain(1'b1);
    check("random_frames", frames_seen - fs0, 3);
    check("random_count", got.size(), ref_got.size());
    for (int i = 0; i < ref_got.size(); i++) begin
      if (i < got.size()) check($sformatf("random_eq%0d", i), got[i], ref_got[i]);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
